// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx
//  Purpose  : Framed serial transmitter: start bit, DATA_W data bits
//             (MSB- or LSB-first), optional parity, one or two stop bits.
//  Revision : 1.0  initial release
// ============================================================================
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 1,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy
);

  localparam int c_timer_w = $clog2(CLKS_PER_BIT + 1);
  localparam int c_cnt_w   = $clog2(DATA_W + 1);

  localparam logic [c_timer_w-1:0] c_timer_load = c_timer_w'(CLKS_PER_BIT - 1);
  localparam logic [c_timer_w-1:0] c_timer_one  = c_timer_w'(1);
  localparam logic [c_cnt_w-1:0]   c_last_bit   = c_cnt_w'(DATA_W - 1);
  localparam logic [c_cnt_w-1:0]   c_last_stop  = c_cnt_w'(STOP_BITS - 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_one    = c_cnt_w'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_timer_w-1:0] r_timer;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [DATA_W-1:0]    r_shreg;
  logic                 r_par;
  logic                 r_txd;

  state_t              w_state_nx;
  logic [c_timer_w-1:0] w_timer_nx;
  logic [c_cnt_w-1:0]   w_cnt_nx;
  logic [DATA_W-1:0]    w_shreg_nx;
  logic                 w_par_nx;
  logic                 w_txd_nx;

  logic                 w_timer_done;
  logic                 w_par_calc;
  logic [DATA_W-1:0]    w_shifted;
  logic                 w_bit_cur;
  logic                 w_bit_shifted;

  // The bit on the line always sits at the outgoing end of the shift register.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shifted     = r_shreg << 1;
      assign w_bit_cur     = r_shreg[DATA_W-1];
      assign w_bit_shifted = w_shifted[DATA_W-1];
    end else begin : g_lsb_first
      assign w_shifted     = r_shreg >> 1;
      assign w_bit_cur     = r_shreg[0];
      assign w_bit_shifted = w_shifted[0];
    end
  endgenerate

  generate
    if (PARITY == 2) begin : g_par_odd
      assign w_par_calc = ~^tx_data;
    end else begin : g_par_even
      assign w_par_calc = ^tx_data;
    end
  endgenerate

  assign w_timer_done = (r_timer == '0);

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_cnt_nx   = r_cnt;
    w_shreg_nx = r_shreg;
    w_par_nx   = r_par;
    w_txd_nx   = r_txd;
    case (r_state)
      S_IDLE: begin
        w_txd_nx = 1'b1;
        if (tx_valid) begin
          w_state_nx = S_START;
          w_txd_nx   = 1'b0;
          w_timer_nx = c_timer_load;
          w_cnt_nx   = '0;
          w_shreg_nx = tx_data;
          w_par_nx   = w_par_calc;
        end
      end
      S_START: begin
        if (w_timer_done) begin
          w_state_nx = S_DATA;
          w_txd_nx   = w_bit_cur;
          w_timer_nx = c_timer_load;
          w_cnt_nx   = '0;
        end else begin
          w_timer_nx = r_timer - c_timer_one;
        end
      end
      S_DATA: begin
        if (w_timer_done) begin
          w_timer_nx = c_timer_load;
          if (r_cnt == c_last_bit) begin
            w_cnt_nx = '0;
            if (PARITY != 0) begin
              w_state_nx = S_PAR;
              w_txd_nx   = r_par;
            end else begin
              w_state_nx = S_STOP;
              w_txd_nx   = 1'b1;
            end
          end else begin
            w_shreg_nx = w_shifted;
            w_txd_nx   = w_bit_shifted;
            w_cnt_nx   = r_cnt + c_cnt_one;
          end
        end else begin
          w_timer_nx = r_timer - c_timer_one;
        end
      end
      S_PAR: begin
        if (w_timer_done) begin
          w_state_nx = S_STOP;
          w_txd_nx   = 1'b1;
          w_timer_nx = c_timer_load;
          w_cnt_nx   = '0;
        end else begin
          w_timer_nx = r_timer - c_timer_one;
        end
      end
      S_STOP: begin
        w_txd_nx = 1'b1;
        if (w_timer_done) begin
          // r_cnt is reused to count stop bits
          if (r_cnt == c_last_stop) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx   = r_cnt + c_cnt_one;
            w_timer_nx = c_timer_load;
          end
        end else begin
          w_timer_nx = r_timer - c_timer_one;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_txd_nx   = 1'b1;
        w_timer_nx = '0;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_cnt   <= w_cnt_nx;
      r_shreg <= w_shreg_nx;
      r_par   <= w_par_nx;
      r_txd   <= w_txd_nx;
    end
  end

  assign tx_ready = (r_state == S_IDLE);
  assign busy     = ~tx_ready;
  assign txd      = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx
//  Purpose  : Self-checking bench for serial_tx across four configurations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data_a [4];
  logic [3:0] valid_v;
  wire  [3:0] ready_v;
  wire  [3:0] txd_v;
  wire  [3:0] busy_v;

  int cpb_p [4] = '{1, 1, 1, 4};
  int msb_p [4] = '{1, 0, 0, 1};
  int par_p [4] = '{0, 1, 2, 0};
  int stp_p [4] = '{1, 1, 1, 2};

  int errors = 0;
  int checks = 0;
  bit exp_q [$];

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .MSB_FIRST(1), .PARITY(0), .STOP_BITS(1)) u_def (
    .clk(clk), .rst(rst), .tx_data(tx_data_a[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .txd(txd_v[0]), .busy(busy_v[0]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .MSB_FIRST(0), .PARITY(1), .STOP_BITS(1)) u_lsb_even (
    .clk(clk), .rst(rst), .tx_data(tx_data_a[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .txd(txd_v[1]), .busy(busy_v[1]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .MSB_FIRST(0), .PARITY(2), .STOP_BITS(1)) u_lsb_odd (
    .clk(clk), .rst(rst), .tx_data(tx_data_a[2]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .txd(txd_v[2]), .busy(busy_v[2]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .MSB_FIRST(1), .PARITY(0), .STOP_BITS(2)) u_slow (
    .clk(clk), .rst(rst), .tx_data(tx_data_a[3]), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .txd(txd_v[3]), .busy(busy_v[3]));

  // Reference: per-cycle line level for one frame, built from the framing rules.
  function automatic void build_frame(int idx, logic [7:0] d);
    int  ones;
    bit  b;
    exp_q.delete();
    for (int c = 0; c < cpb_p[idx]; c++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      b = (msb_p[idx] != 0) ? d[7-i] : d[i];
      for (int c = 0; c < cpb_p[idx]; c++) exp_q.push_back(b);
    end
    if (par_p[idx] != 0) begin
      ones = $countones(d);
      b = ((ones % 2) == 1);
      if (par_p[idx] == 2) b = !b;
      for (int c = 0; c < cpb_p[idx]; c++) exp_q.push_back(b);
    end
    for (int c = 0; c < stp_p[idx] * cpb_p[idx]; c++) exp_q.push_back(1'b1);
  endfunction

  task automatic start_frame(int idx, logic [7:0] d);
    @(negedge clk);
    checks++;
    if (ready_v[idx] !== 1'b1 || txd_v[idx] !== 1'b1) begin
      errors++;
      $display("FAIL pre_accept dut%0d: ready=%b txd=%b, want ready=1 txd=1", idx, ready_v[idx], txd_v[idx]);
    end
    tx_data_a[idx] = d;
    valid_v[idx]   = 1'b1;
    @(posedge clk);
  endtask

  // Called right after the accepting edge; also checks the idle cycle after the frame.
  task automatic check_frame(int idx, logic [7:0] d, bit keep_valid, logic [7:0] mid);
    int f;
    build_frame(idx, d);
    f = exp_q.size();
    for (int j = 0; j < f; j++) begin
      @(negedge clk);
      if (j == 0) begin
        tx_data_a[idx] = mid;
        if (!keep_valid) valid_v[idx] = 1'b0;
      end
      checks++;
      if (txd_v[idx] !== exp_q[j]) begin
        errors++;
        $display("FAIL txd dut%0d data=%h cycle=%0d: got %b want %b", idx, d, j, txd_v[idx], exp_q[j]);
      end
      checks++;
      if (ready_v[idx] !== 1'b0 || busy_v[idx] !== 1'b1) begin
        errors++;
        $display("FAIL ready_busy dut%0d data=%h cycle=%0d: ready=%b busy=%b want 0/1",
                 idx, d, j, ready_v[idx], busy_v[idx]);
      end
    end
    @(negedge clk);
    checks++;
    if ({txd_v[idx], ready_v[idx], busy_v[idx]} !== 3'b110) begin
      errors++;
      $display("FAIL idle_after dut%0d data=%h: txd/ready/busy=%b want 110",
               idx, d, {txd_v[idx], ready_v[idx], busy_v[idx]});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_v = 4'h0;
    for (int i = 0; i < 4; i++) tx_data_a[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (txd_v !== 4'hF || ready_v !== 4'hF || busy_v !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: txd=%b ready=%b busy=%b want 1111/1111/0000", txd_v, ready_v, busy_v);
    end
    rst = 1'b0;
  endtask

  task automatic test_default();
    start_frame(0, 8'hA5);
    check_frame(0, 8'hA5, 1'b0, 8'h5A);
  endtask

  task automatic test_lsb_parity();
    start_frame(1, 8'hA5);
    check_frame(1, 8'hA5, 1'b0, 8'h00);
    start_frame(2, 8'hA5);
    check_frame(2, 8'hA5, 1'b0, 8'hFF);
  endtask

  task automatic test_slow_two_stop();
    start_frame(3, 8'h3C);
    check_frame(3, 8'h3C, 1'b0, 8'hC3);
  endtask

  task automatic test_back_to_back();
    start_frame(0, 8'h00);
    check_frame(0, 8'h00, 1'b1, 8'hFF);
    check_frame(0, 8'hFF, 1'b0, 8'h00);
  endtask

  task automatic test_rst_mid_frame();
    start_frame(0, 8'h81);
    build_frame(0, 8'h81);
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      if (j == 0) valid_v[0] = 1'b0;
      checks++;
      if (txd_v[0] !== exp_q[j]) begin
        errors++;
        $display("FAIL rst_pre_txd cycle=%0d: got %b want %b", j, txd_v[0], exp_q[j]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({txd_v[0], ready_v[0], busy_v[0]} !== 3'b110) begin
      errors++;
      $display("FAIL rst_abort: txd/ready/busy=%b want 110", {txd_v[0], ready_v[0], busy_v[0]});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({txd_v[0], ready_v[0], busy_v[0]} !== 3'b110) begin
      errors++;
      $display("FAIL rst_stay_idle: txd/ready/busy=%b want 110", {txd_v[0], ready_v[0], busy_v[0]});
    end
    start_frame(0, 8'h96);
    check_frame(0, 8'h96, 1'b0, 8'h00);
  endtask

  task automatic test_rst_with_valid();
    @(negedge clk);
    rst = 1'b1;
    tx_data_a[0] = 8'h00;
    valid_v[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({txd_v[0], ready_v[0], busy_v[0]} !== 3'b110) begin
      errors++;
      $display("FAIL rst_beats_valid: txd/ready/busy=%b want 110", {txd_v[0], ready_v[0], busy_v[0]});
    end
    rst = 1'b0;
    valid_v[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL rst_valid_idle cycle=%0d: txd=%b busy=%b want 1/0", j, txd_v[0], busy_v[0]);
      end
    end
  endtask

  task automatic test_random();
    int         idx;
    int         gap;
    logic [7:0] d;
    logic [7:0] m;
    for (int n = 0; n < 24; n++) begin
      idx = $urandom_range(0, 3);
      d   = 8'($urandom);
      m   = 8'($urandom);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if (txd_v[idx] !== 1'b1 || ready_v[idx] !== 1'b1) begin
          errors++;
          $display("FAIL random_gap dut%0d: txd=%b ready=%b want 1/1", idx, txd_v[idx], ready_v[idx]);
        end
      end
      start_frame(idx, d);
      check_frame(idx, d, 1'b0, m);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_lsb_parity();
    test_slow_two_stop();
    test_back_to_back();
    test_rst_mid_frame();
    test_rst_with_valid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
